// File: rtl/id_ex_decode_stage.sv
// Decode stage and ID/EX pipeline register for the RV64 pipelined core.
// Turns the fetched instruction into main control, ALUOp/Funct, register
// indices and a sign-extended immediate. It also detects load-use hazards,
// which cause a stall plus a bubble, and honours branch flushes from EX.
module id_ex_decode_stage #(
  parameter int XLEN      = 64,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            stall,
  output logic            illegal,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [1:0]      ex_ALUOp,
  output logic [3:0]      ex_Funct,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_MemtoReg,
  output logic            ex_ALUSrc,
  output logic            ex_Branch
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Raw instruction fields. These are passed through unchanged, even for
  // formats that do not use them.
  logic [6:0] opcode;
  logic [4:0] if_rs1, if_rs2, if_rd;
  logic [3:0] funct;

  assign opcode = if_instr[6:0];
  assign if_rd  = if_instr[11:7];
  assign if_rs1 = if_instr[19:15];
  assign if_rs2 = if_instr[24:20];
  assign funct  = {if_instr[30], if_instr[14:12]};

  // Immediate formats, each sign-extended from instruction bit 31.
  logic [XLEN-1:0] imm_i, imm_s, imm_b;

  assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                  if_instr[30:25], if_instr[11:8], 1'b0};

  logic            legal, uses_rs2;
  logic [1:0]      d_aluop;
  logic            d_alusrc, d_regwrite, d_memread, d_memwrite, d_memtoreg, d_branch;
  logic [XLEN-1:0] d_imm;

  // Main decoder: opcode -> control bits, immediate select, rs2 usage.
  always_comb begin
    legal      = 1'b1;
    uses_rs2   = 1'b0;
    d_aluop    = 2'b00;
    d_alusrc   = 1'b0;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_memtoreg = 1'b0;
    d_branch   = 1'b0;
    d_imm      = '0;
    case (opcode)
      OP_R: begin
        d_aluop    = 2'b10;
        d_regwrite = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_I: begin
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_imm      = imm_i;
      end
      OP_LD: begin
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_memread  = 1'b1;
        d_memtoreg = 1'b1;
        d_imm      = imm_i;
      end
      OP_ST: begin
        d_alusrc   = 1'b1;
        d_memwrite = 1'b1;
        uses_rs2   = 1'b1;
        d_imm      = imm_s;
      end
      OP_BR: begin
        d_aluop  = 2'b01;
        d_branch = 1'b1;
        uses_rs2 = 1'b1;
        d_imm    = imm_b;
      end
      default: legal = 1'b0;
    endcase
  end

  // Load-use hazard: the load now in EX writes a register this instruction
  // reads. An rd of x0 never causes a hazard, and an illegal incoming
  // instruction never raises one.
  logic hz;

  generate
    if (HAZARD_EN) begin : g_hz
      assign hz = if_valid & legal & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                  ((ex_rd == if_rs1) | (uses_rs2 & (ex_rd == if_rs2)));
    end else begin : g_no_hz
      assign hz = 1'b0;
    end
  endgenerate

  // When a flush coincides with a hazard, IF is redirected anyway, so there
  // is nothing to hold.
  assign stall = hz & ~flush;

  logic bubble, illegal_next;

  assign bubble       = flush | hz | ~if_valid | ~legal;
  assign illegal_next = if_valid & ~flush & ~hz & ~legal;

  // ID/EX register: reset, then bubble, then the decoded instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal     <= 1'b0;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ALUOp    <= '0;
      ex_Funct    <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
    end else begin
      illegal <= illegal_next;
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_ALUOp    <= '0;
        ex_Funct    <= '0;
        ex_RegWrite <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_Branch   <= 1'b0;
      end else begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_imm      <= d_imm;
        ex_rs1      <= if_rs1;
        ex_rs2      <= if_rs2;
        ex_rd       <= if_rd;
        ex_ALUOp    <= d_aluop;
        ex_Funct    <= funct;
        ex_RegWrite <= d_regwrite;
        ex_MemRead  <= d_memread;
        ex_MemWrite <= d_memwrite;
        ex_MemtoReg <= d_memtoreg;
        ex_ALUSrc   <= d_alusrc;
        ex_Branch   <= d_branch;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Testbench for id_ex_decode_stage. A behavioural model predicts every EX
// output and stall, and is compared with the DUT each cycle. Directed
// scenarios add hand-computed literal checks on top of the model.
module tb_id_ex_decode_stage;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        stall, illegal, ex_valid;
  logic [63:0] ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  ex_ALUOp;
  logic [3:0]  ex_Funct;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_decode_stage #(.XLEN(64), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .stall(stall), .illegal(illegal),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ALUOp(ex_ALUOp), .ex_Funct(ex_Funct),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch)
  );

  // Expected registered state: every output except stall.
  typedef struct packed {
    logic        ill;
    logic        v;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic        rw, mr, mw, m2r, as, br;
  } ex_t;

  ex_t model, model_next;
  ex_t dut_vec;
  logic last_stall;

  assign dut_vec = {illegal, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ALUOp,
                    ex_Funct, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
                    ex_ALUSrc, ex_Branch};

  function automatic bit is_legal(logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  endfunction

  function automatic bit reads_rs2(logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Decoder model: a control table read from the opcode, and immediates
  // built from signed arithmetic on the instruction word.
  function automatic ex_t decode(logic [31:0] ins, logic [63:0] pc);
    ex_t e;
    logic [7:0] ctl;
    longint si;
    longint im;
    e  = '0;
    si = longint'($signed(ins));
    im = 0;
    ctl = 8'b0;
    case (ins[6:0])
      7'h33: ctl = 8'b10_0_1_0_0_0_0;
      7'h13: begin ctl = 8'b00_1_1_0_0_0_0; im = si >>> 20; end
      7'h03: begin ctl = 8'b00_1_1_1_0_1_0; im = si >>> 20; end
      7'h23: begin ctl = 8'b00_1_0_0_1_0_0; im = ((si >>> 25) * 32) + longint'(ins[11:7]); end
      7'h63: begin
        ctl = 8'b01_0_0_0_0_0_1;
        im  = ((si >>> 31) * 4096) + longint'(ins[7]) * 2048 +
              longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      default: ctl = 8'b0;
    endcase
    e.v     = 1'b1;
    e.pc    = pc;
    e.imm   = im;
    e.rs1   = ins[19:15];
    e.rs2   = ins[24:20];
    e.rd    = ins[11:7];
    e.funct = {ins[30], ins[14:12]};
    e.aluop = ctl[7:6];
    e.as    = ctl[5];
    e.rw    = ctl[4];
    e.mr    = ctl[3];
    e.mw    = ctl[2];
    e.m2r   = ctl[1];
    e.br    = ctl[0];
    return e;
  endfunction

  function automatic bit model_hz(ex_t m, logic v, logic [31:0] ins);
    logic [4:0] r1, r2;
    r1 = ins[19:15];
    r2 = ins[24:20];
    return v && is_legal(ins) && m.v && m.mr && (m.rd != 0) &&
           ((m.rd == r1) || (reads_rs2(ins) && m.rd == r2));
  endfunction

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: compare registered outputs, drive inputs, check stall,
  // advance the model, then wait for the edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                      input logic [63:0] pc, input logic fl);
    bit hz;
    @(negedge clk);
    check("ex_state", 160'(dut_vec), 160'(model));
    reset = rst; if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    #1;
    hz = model_hz(model, v, ins);
    check("stall", 160'(stall), 160'(hz && !fl));
    last_stall = stall;
    if (rst)                      model_next = '0;
    else if (fl || hz || !v)      model_next = '0;
    else if (!is_legal(ins)) begin model_next = '0; model_next.ill = 1'b1; end
    else                          model_next = decode(ins, pc);
    $display("[TB] t=%0t rst=%0b v=%0b instr=%h fl=%0b stall=%0b", $time, rst, v, ins, fl, stall);
    @(posedge clk);
    model = model_next;
    #1;
  endtask

  logic [31:0] ins;
  logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};

  initial begin
    reset = 1'b1; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 64'h100; flush = 1'b0;
    model = '0;
    last_stall = 1'b0;

    // T1: reset held for two cycles with a valid instruction present
    step(1, 1, 32'h002081B3, 64'h100, 0);
    step(1, 1, 32'h002081B3, 64'h100, 0);
    check("reset_zero", 160'(dut_vec), 160'd0);
    check("reset_stall", 160'(stall), 160'd0);

    // T2: add and sub
    step(0, 1, 32'h002081B3, 64'h200, 0);
    check("add_fields", 160'({ex_valid, ex_ALUOp, ex_Funct, ex_RegWrite, ex_ALUSrc, ex_rd, ex_rs1, ex_rs2}),
          160'({1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2}));
    step(0, 1, 32'h402081B3, 64'h204, 0);
    check("sub_funct", 160'(ex_Funct), 160'(4'b1000));

    // T3: slli and beq
    step(0, 1, 32'h00329293, 64'h208, 0);
    check("slli", 160'({ex_ALUOp, ex_Funct, ex_ALUSrc, ex_imm}), 160'({2'b00, 4'b0001, 1'b1, 64'd3}));
    step(0, 1, 32'hFE208CE3, 64'h20C, 0);
    check("beq", 160'({ex_ALUOp, ex_Branch, ex_imm}), 160'({2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8}));

    // T4: load-use stall and an rd=x0 load that must not stall
    step(0, 1, 32'h0000B283, 64'h300, 0);
    step(0, 1, 32'h00228333, 64'h304, 0);
    check("lu_stall", 160'({last_stall, ex_valid}), 160'({1'b1, 1'b0}));
    step(0, 1, 32'h00228333, 64'h304, 0);
    check("lu_resume", 160'({last_stall, ex_valid, ex_rd, ex_pc}), 160'({1'b0, 1'b1, 5'd6, 64'h304}));
    step(0, 1, 32'h0000B003, 64'h308, 0);
    step(0, 1, 32'h00200333, 64'h30C, 0);
    check("x0_no_stall", 160'({last_stall, ex_valid}), 160'({1'b0, 1'b1}));

    // T5: hazard together with a flush, then an unsupported opcode
    step(0, 1, 32'h0000B283, 64'h400, 0);
    step(0, 1, 32'h00228333, 64'h404, 1);
    check("flush_hz", 160'({last_stall, ex_valid}), 160'({1'b0, 1'b0}));
    step(0, 1, 32'h0000007F, 64'h408, 0);
    check("illegal", 160'({illegal, ex_valid}), 160'({1'b1, 1'b0}));
    step(0, 0, 32'h0000007F, 64'h40C, 0);
    check("illegal_pulse", 160'(illegal), 160'd0);

    // T6: reset asserted while a load-use pair is stalled
    step(0, 1, 32'h0000B283, 64'h500, 0);
    step(1, 1, 32'h00228333, 64'h504, 0);
    check("t6_reset", 160'(dut_vec), 160'd0);
    step(0, 1, 32'h00228333, 64'h504, 0);
    check("t6_resume", 160'({last_stall, ex_valid, ex_rd}), 160'({1'b0, 1'b1, 5'd6}));

    // Random traffic. Registers are drawn from a small pool so that hazards
    // occur often; IF holds its instruction while the model predicts a stall.
    ins = 32'h00000013;
    for (int i = 0; i < 400; i++) begin
      logic v, fl, rs;
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 49) == 0);
      if (!last_stall) begin
        ins = $urandom();
        ins[6:0]   = ops[$urandom_range(0, 5)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end else begin
        v = 1'b1;
      end
      step(rs, v, ins, {32'h0, $urandom()}, fl);
    end

    @(negedge clk);
    check("final_state", 160'(dut_vec), 160'(model));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
